// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs mult/div with fixed latency,
// and services mfhi/mflo/mthi/mtlo.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W_RAW  = $clog2(MAX_CYCLES + 1);
  localparam int unsigned CNT_W      = (CNT_W_RAW < 4) ? 4 : CNT_W_RAW;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      p_hi_q, p_hi_d, p_lo_q, p_lo_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] divisor, a_mag, b_mag, sq_mag, sr_mag, sq, sr, uq, ur;
  logic        b_zero;

  // Sign-extending to 64 bits lets one unsigned multiplier form the signed product.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Divide by zero keeps HI/LO, so a dummy divisor of 1 keeps the datapath defined.
  assign b_zero  = (B == 32'd0);
  assign divisor = b_zero ? 32'd1 : B;
  assign a_mag   = A[31] ? (32'd0 - A) : A;
  assign b_mag   = divisor[31] ? (32'd0 - divisor) : divisor;
  assign sq_mag  = a_mag / b_mag;
  assign sr_mag  = a_mag % b_mag;
  assign sq      = (A[31] ^ divisor[31]) ? (32'd0 - sq_mag) : sq_mag;
  assign sr      = A[31] ? (32'd0 - sr_mag) : sr_mag;
  assign uq      = A / divisor;
  assign ur      = A % divisor;

  assign busy = (cnt_q != '0);
  assign HI   = hi_q;
  assign LO   = lo_q;

  // Next-state: countdown/commit has priority; otherwise accept a new op or move.
  always_comb begin
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    p_hi_d = p_hi_q;
    p_lo_d = p_lo_q;
    if (busy) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        hi_d = p_hi_q;
        lo_d = p_lo_q;
      end
    end else if (!Req) begin
      case (mdu_op)
        OP_MULT: if (start) begin
          cnt_d  = CNT_W'(MULT_CYCLES);
          p_hi_d = prod_s[63:32];
          p_lo_d = prod_s[31:0];
        end
        OP_MULTU: if (start) begin
          cnt_d  = CNT_W'(MULT_CYCLES);
          p_hi_d = prod_u[63:32];
          p_lo_d = prod_u[31:0];
        end
        OP_DIV: if (start) begin
          cnt_d  = CNT_W'(DIV_CYCLES);
          p_hi_d = b_zero ? hi_q : sr;
          p_lo_d = b_zero ? lo_q : sq;
        end
        OP_DIVU: if (start) begin
          cnt_d  = CNT_W'(DIV_CYCLES);
          p_hi_d = b_zero ? hi_q : ur;
          p_lo_d = b_zero ? lo_q : uq;
        end
        OP_MTHI: hi_d = A;
        OP_MTLO: lo_d = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      p_hi_q <= '0;
      p_lo_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      p_hi_q <= p_hi_d;
      p_lo_q <= p_lo_d;
    end
  end

  always_comb begin
    case (mdu_op)
      OP_MFHI: out = hi_q;
      OP_MFLO: out = lo_q;
      default: out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu: arithmetic, latency, moves, Req and reset.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset, Req, start;
  logic [3:0]  mdu_op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] out, HI, LO;

  int errors = 0;
  int checks = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Req(Req), .start(start), .mdu_op(mdu_op),
    .A(A), .B(B), .busy(busy), .out(out), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one op for a single edge, then counts busy cycles (bounded).
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n);
    start = 1'b1; mdu_op = op; A = a; B = b;
    step();
    start = 1'b0; mdu_op = 4'd0; A = 32'd0; B = 32'd0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; Req = 1'b0; start = 1'b0; mdu_op = 4'd0; A = 32'd0; B = 32'd0;
    step(); step();
    reset = 1'b0;
    mdu_op = 4'd5; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h exp 00000000", HI); end
    checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h exp 00000000", LO); end
    checks++; if (out !== 32'd0) begin errors++; $display("FAIL reset_out: got %h exp 00000000", out); end
    mdu_op = 4'd0;
  endtask

  task automatic test_mult();
    int n;
    issue(4'd1, 32'hFFFFFFFE, 32'd3, n);
    checks++; if (n != 5) begin errors++; $display("FAIL mult_latency: got %0d exp 5", n); end
    checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h exp ffffffff", HI); end
    checks++; if (LO !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo: got %h exp fffffffa", LO); end
    mdu_op = 4'd6; #1;
    checks++; if (out !== 32'hFFFFFFFA) begin errors++; $display("FAIL mflo_out: got %h exp fffffffa", out); end
    mdu_op = 4'd0;
  endtask

  task automatic test_multu();
    int n;
    issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
    checks++; if (n != 5) begin errors++; $display("FAIL multu_latency: got %0d exp 5", n); end
    checks++; if (HI !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h exp fffffffe", HI); end
    checks++; if (LO !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h exp 00000001", LO); end
  endtask

  task automatic test_div();
    int n;
    issue(4'd3, 32'hFFFFFFF9, 32'd2, n);
    checks++; if (n != 10) begin errors++; $display("FAIL div_latency: got %0d exp 10", n); end
    checks++; if (LO !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h exp fffffffd", LO); end
    checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h exp ffffffff", HI); end
    issue(4'd4, 32'd7, 32'd0, n);
    checks++; if (n != 10) begin errors++; $display("FAIL divu0_latency: got %0d exp 10", n); end
    checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu0_hi: got %h exp ffffffff", HI); end
    checks++; if (LO !== 32'hFFFFFFFD) begin errors++; $display("FAIL divu0_lo: got %h exp fffffffd", LO); end
    issue(4'd4, 32'd100, 32'd7, n);
    checks++; if (LO !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h exp 0000000e", LO); end
    checks++; if (HI !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h exp 00000002", HI); end
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF, n);
    checks++; if (LO !== 32'h80000000) begin errors++; $display("FAIL divmin_lo: got %h exp 80000000", LO); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL divmin_hi: got %h exp 00000000", HI); end
  endtask

  task automatic test_moves();
    Req = 1'b1; mdu_op = 4'd7; A = 32'h12345678;
    step();
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL mthi_req: got %h exp 00000000", HI); end
    Req = 1'b0;
    step();
    checks++; if (HI !== 32'h12345678) begin errors++; $display("FAIL mthi: got %h exp 12345678", HI); end
    mdu_op = 4'd5; #1;
    checks++; if (out !== 32'h12345678) begin errors++; $display("FAIL mfhi_out: got %h exp 12345678", out); end
    mdu_op = 4'd8; A = 32'hCAFEF00D;
    step();
    checks++; if (LO !== 32'hCAFEF00D) begin errors++; $display("FAIL mtlo: got %h exp cafef00d", LO); end
    mdu_op = 4'd0; A = 32'd0;
  endtask

  task automatic test_req();
    int n;
    start = 1'b1; Req = 1'b1; mdu_op = 4'd1; A = 32'd9; B = 32'd9;
    step();
    start = 1'b0; Req = 1'b0; mdu_op = 4'd0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_req_busy: got %b exp 0", busy); end
    checks++; if (HI !== 32'h12345678 || LO !== 32'hCAFEF00D) begin
      errors++; $display("FAIL start_req_hilo: got %h/%h exp 12345678/cafef00d", HI, LO); end
    // Div with a Req pulse at busy cycle 3 and a blocked mthi at busy cycle 5.
    start = 1'b1; mdu_op = 4'd3; A = 32'd100; B = 32'hFFFFFFF9;
    step();
    start = 1'b0; mdu_op = 4'd0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      Req    = (n == 3);
      mdu_op = (n == 5) ? 4'd7 : 4'd0;
      A      = (n == 5) ? 32'hDEADBEEF : 32'd0;
      step();
      if (n == 5) begin
        checks++; if (HI !== 32'h12345678) begin errors++; $display("FAIL mthi_busy: got %h exp 12345678", HI); end
      end
    end
    Req = 1'b0; mdu_op = 4'd0; A = 32'd0;
    checks++; if (n != 10) begin errors++; $display("FAIL div_req_latency: got %0d exp 10", n); end
    checks++; if (LO !== 32'hFFFFFFF2) begin errors++; $display("FAIL div_req_lo: got %h exp fffffff2", LO); end
    checks++; if (HI !== 32'd2) begin errors++; $display("FAIL div_req_hi: got %h exp 00000002", HI); end
  endtask

  task automatic test_reset_mid_op();
    start = 1'b1; mdu_op = 4'd1; A = 32'd3; B = 32'd4;
    step();
    start = 1'b0; mdu_op = 4'd0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b exp 0", busy); end
    checks++; if (HI !== 32'd0 || LO !== 32'd0) begin
      errors++; $display("FAIL rst_mid_hilo: got %h/%h exp 00000000/00000000", HI, LO); end
    for (int i = 0; i < 8; i++) step();
    checks++; if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_no_commit: got %h/%h busy=%b exp 0/0 busy=0", HI, LO, busy); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_moves();
    test_req();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
